lsu: RTL and testbench

Load/store unit for the execute-to-memory boundary. It takes the effective address produced by the ALU (`alu_result`) plus the store data and access type of a memory instruction. It performs one transaction on the data-memory bus with byte-lane steering, and returns sign- or zero-extended load data to writeback. A valid/ready handshake toward the pipeline lets the control path stall on memory wait states.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_load_extend.sv | 40 ++++
 rtl/lsu.sv | 155 +++++++++++++++
 tb/tb_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 access-size codes (LSU_F3_*)
//   - FSM state encoding (lsu_state_t)
//   - helpers for store byte-lane steering and misalignment detection
package lsu_pkg;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Byte enables for a store. Unknown size codes behave as a full word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LSU_F3_B, LSU_F3_BU: store_be = 4'b0001 << lo;
      LSU_F3_H, LSU_F3_HU: store_be = 4'b0011 << {lo[1], 1'b0};
      default:             store_be = 4'b1111;
    endcase
  endfunction

  // Write data replicated across lanes so the enabled lanes see the operand
  // regardless of the byte offset.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      LSU_F3_B, LSU_F3_BU: store_wdata = {4{d[7:0]}};
      LSU_F3_H, LSU_F3_HU: store_wdata = {2{d[15:0]}};
      default:             store_wdata = d;
    endcase
  endfunction

  // Halves need addr[0]=0, words (including undefined codes) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LSU_F3_B, LSU_F3_BU: is_misaligned = 1'b0;
      LSU_F3_H, LSU_F3_HU: is_misaligned = lo[0];
      default:             is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// load_extend: combinational load-data extraction and extension.
// Ports:
//   rdata   in  32  raw word from the data bus
//   addr_lo in  2   low address bits selecting the byte/half lane
//   funct3  in  3   access size and sign (bit 2 set = zero-extend)
//   ext     out 32  extended load result
// Halves select the lane with addr_lo[1] only; undefined codes return the word.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      LSU_F3_B:  ext = {{24{byte_val[7]}}, byte_val};
      LSU_F3_BU: ext = {24'h0, byte_val};
      LSU_F3_H:  ext = {{16{half_val[15]}}, half_val};
      LSU_F3_HU: ext = {16'h0, half_val};
      default:   ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the data-memory bus.
// One request is accepted in IDLE, performed as a single bus transfer in REQ
// (held stable until dmem_ack), and reported with a one-cycle resp_valid in RESP.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     pipeline handshake (ready only in IDLE)
//   alu_result, store_data    effective address, store operand
//   mem_read, mem_write       direction (write wins when both set)
//   funct3                    access size / sign
//   resp_valid, load_data     completion pulse and extended load result
//   misaligned                misaligned-access flag (valid with resp_valid)
//   dmem_req/we/addr/wdata/be bus request, driven only in REQ
//   dmem_ack, dmem_rdata      bus completion and read word
// Configuration: define LSU_MISALIGN_TRAP_EN to suppress misaligned bus
// accesses and report them through misaligned; otherwise misaligned is 0 and
// the offending low address bits are ignored.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic [2:0]  f3_reg, f3_next;
  logic        we_reg, we_next;
  logic [31:0] load_data_reg, load_data_next;
  logic [31:0] ext_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis_reg, mis_next;
`endif

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (addr_reg[1:0]),
    .funct3  (f3_reg),
    .ext     (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      f3_reg        <= '0;
      we_reg        <= 1'b0;
      load_data_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      f3_reg        <= f3_next;
      we_reg        <= we_next;
      load_data_reg <= load_data_next;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_reg       <= mis_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    f3_next        = f3_reg;
    we_next        = we_reg;
    load_data_next = load_data_reg;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_next       = mis_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          addr_next = alu_result;
          f3_next   = funct3;
          we_next   = mem_write;
          // Loads read the whole word and pick the lane on return.
          be_next    = mem_write ? store_be(funct3, alu_result[1:0]) : 4'b1111;
          wdata_next = mem_write ? store_wdata(funct3, store_data) : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_next  = 1'b0;
`endif
          if (!mem_read && !mem_write) begin
            // Not a memory op: complete without touching the bus.
            state_next     = ST_RESP;
            load_data_next = 32'h0;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (is_misaligned(funct3, alu_result[1:0])) begin
            state_next     = ST_RESP;
            load_data_next = 32'h0;
            mis_next       = 1'b1;
          end
`endif
          else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_ack) begin
          load_data_next = we_reg ? 32'h0 : ext_data;
          state_next     = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are gated by state so that an asynchronous reset drops them
  // at once and nothing is driven outside REQ.
  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    resp_valid = (state_reg == ST_RESP);
    dmem_req   = (state_reg == ST_REQ);
    dmem_we    = dmem_req & we_reg;
    dmem_addr  = dmem_req ? {addr_reg[31:2], 2'b00} : 32'h0;
    dmem_wdata = dmem_req ? wdata_reg : 32'h0;
    dmem_be    = dmem_req ? be_reg : 4'b0000;
    load_data  = load_data_reg;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = mis_reg;
`else
    misaligned = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'hBAD0BAD0;

  int vectors = 0;
  int miscompares = 0;

  // Observations from the most recent transaction
  logic        obs_req;
  logic        obs_we;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_stable;
  logic        obs_ready_low;
  int          obs_resp_cyc;
  logic [31:0] obs_load;
  logic        obs_mis;
  logic        obs_ready_after;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  // Drives one request and plays the memory side, acking after wait_cycles
  // cycles of dmem_req. obs_resp_cyc counts cycles from the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int wait_cycles);
    int waited;
    waited = 0;
    obs_req = 1'b0; obs_stable = 1'b1; obs_ready_low = 1'b1; obs_resp_cyc = -1;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_load = '0; obs_mis = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = data;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = 32'hFFFF_FFFF; store_data = 32'h5555_5555; funct3 = 3'b111;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid) begin
        obs_resp_cyc = c; obs_load = load_data; obs_mis = misaligned;
        break;
      end
      if (dmem_req) begin
        if (!obs_req) begin
          obs_we = dmem_we; obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_be = dmem_be;
        end else if (dmem_we !== obs_we || dmem_addr !== obs_addr ||
                     dmem_wdata !== obs_wdata || dmem_be !== obs_be) begin
          obs_stable = 1'b0;
        end
        obs_req = 1'b1;
        if (req_ready !== 1'b0) obs_ready_low = 1'b0;
        if (waited == wait_cycles) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          waited++;
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'hBAD0BAD0;
    end
    @(posedge clk); #1;
    obs_ready_after = req_ready;
  endtask

  task automatic test_reset();
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp got %b want 0", resp_valid); end
    vectors++;
    if (load_data !== 32'h0 || misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_load got %h/%b want 0/0", load_data, misaligned); end
    vectors++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
      miscompares++; $display("FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h be=%b want all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
    end
    vectors++;
  endtask

  task automatic test_sw();
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    $display("SW  addr=100 addr=%h be=%b wdata=%h we=%b resp_cyc=%0d", obs_addr, obs_be, obs_wdata, obs_we, obs_resp_cyc);
    if ({obs_addr, obs_be, obs_wdata, obs_we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      miscompares++; $display("FAIL sw_bus got %h %b %h %b want 00000100 1111 deadbeef 1", obs_addr, obs_be, obs_wdata, obs_we);
    end
    vectors++;
    if (obs_resp_cyc !== 2) begin miscompares++; $display("FAIL sw_latency got %0d want 2", obs_resp_cyc); end
    vectors++;
    if (obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL sw_ready_after got %b want 1", obs_ready_after); end
    vectors++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [31:0] rd_t [5] = '{32'h12807F00, 32'h12807F00, 32'h80010000, 32'h80010000, 32'h0BADF00D};
    logic [31:0] exp_t[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0BADF00D};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, f3_t[i], (i == 4) ? 32'h104 : 32'h102, 32'h0, rd_t[i], 0);
      $display("LD  f3=%b rdata=%h load=%h be=%b we=%b", f3_t[i], rd_t[i], obs_load, obs_be, obs_we);
      if (obs_load !== exp_t[i]) begin miscompares++; $display("FAIL load_%0d got %h want %h", i, obs_load, exp_t[i]); end
      vectors++;
      if ({obs_be, obs_we, obs_resp_cyc} !== {4'b1111, 1'b0, 32'd2}) begin
        miscompares++; $display("FAIL load_bus_%0d got be=%b we=%b cyc=%0d want 1111 0 2", i, obs_be, obs_we, obs_resp_cyc);
      end
      vectors++;
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3_t [3] = '{3'b000, 3'b001, 3'b111};
    logic [31:0] ad_t [3] = '{32'h103, 32'h102, 32'h104};
    logic [31:0] d_t  [3] = '{32'h000000A5, 32'h1234ABCD, 32'h01020304};
    logic [3:0]  be_t [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wd_t [3] = '{32'hA5A5A5A5, 32'hABCDABCD, 32'h01020304};
    logic [31:0] ea_t [3] = '{32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, f3_t[i], ad_t[i], d_t[i], 32'hFFFFFFFF, 0);
      $display("ST  f3=%b addr=%h be=%b wdata=%h load=%h", f3_t[i], obs_addr, obs_be, obs_wdata, obs_load);
      if ({obs_addr, obs_be, obs_wdata} !== {ea_t[i], be_t[i], wd_t[i]}) begin
        miscompares++; $display("FAIL store_%0d got %h %b %h want %h %b %h", i, obs_addr, obs_be, obs_wdata, ea_t[i], be_t[i], wd_t[i]);
      end
      vectors++;
      if (obs_load !== 32'h0) begin miscompares++; $display("FAIL store_load_zero_%0d got %h want 0", i, obs_load); end
      vectors++;
    end
    // Both read and write set: the write wins.
    issue(1'b1, 1'b1, 3'b010, 32'h108, 32'h55AA55AA, 32'h0, 0);
    $display("RW  we=%b wdata=%h", obs_we, obs_wdata);
    if (obs_we !== 1'b1 || obs_wdata !== 32'h55AA55AA) begin miscompares++; $display("FAIL rw_priority got we=%b wdata=%h want 1 55aa55aa", obs_we, obs_wdata); end
    vectors++;
  endtask

  task automatic test_lw_wait();
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 3);
    $display("LWW addr=%h load=%h resp_cyc=%0d stable=%b ready_low=%b", obs_addr, obs_load, obs_resp_cyc, obs_stable, obs_ready_low);
    if (obs_stable !== 1'b1 || obs_addr !== 32'h200) begin miscompares++; $display("FAIL lw_wait_stable got stable=%b addr=%h want 1 00000200", obs_stable, obs_addr); end
    vectors++;
    if (obs_ready_low !== 1'b1) begin miscompares++; $display("FAIL lw_wait_ready got %b want ready low (1)", obs_ready_low); end
    vectors++;
    if (obs_resp_cyc !== 5) begin miscompares++; $display("FAIL lw_wait_latency got %0d want 5", obs_resp_cyc); end
    vectors++;
    if (obs_load !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lw_wait_data got %h want cafef00d", obs_load); end
    vectors++;
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0);
    $display("MIS req=%b addr=%h be=%b mis=%b load=%h resp_cyc=%0d", obs_req, obs_addr, obs_be, obs_mis, obs_load, obs_resp_cyc);
`ifdef LSU_MISALIGN_TRAP_EN
    if (obs_req !== 1'b0) begin miscompares++; $display("FAIL mis_noreq got %b want 0", obs_req); end
    vectors++;
    if (obs_mis !== 1'b1 || obs_load !== 32'h0 || obs_resp_cyc !== 1) begin
      miscompares++; $display("FAIL mis_resp got mis=%b load=%h cyc=%0d want 1 0 1", obs_mis, obs_load, obs_resp_cyc);
    end
    vectors++;
`else
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111) begin miscompares++; $display("FAIL mis_access got %h %b want 00000100 1111", obs_addr, obs_be); end
    vectors++;
    if (obs_mis !== 1'b0 || obs_load !== 32'h11223344 || obs_resp_cyc !== 2) begin
      miscompares++; $display("FAIL mis_resp got mis=%b load=%h cyc=%0d want 0 11223344 2", obs_mis, obs_load, obs_resp_cyc);
    end
    vectors++;
`endif
  endtask

  task automatic test_noop();
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h77777777, 0);
    issue(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0);
    $display("NOP req=%b load=%h resp_cyc=%0d", obs_req, obs_load, obs_resp_cyc);
    if (obs_req !== 1'b0 || obs_resp_cyc !== 1 || obs_load !== 32'h0) begin
      miscompares++; $display("FAIL noop got req=%b cyc=%0d load=%h want 0 1 0", obs_req, obs_resp_cyc, obs_load);
    end
    vectors++;
  endtask

  task automatic test_rst_mid_req();
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0;
    if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rstreq_pre got %b want 1", dmem_req); end
    vectors++;
    #2 rst = 1'b1;
    #1;
    $display("RST dmem_req=%b req_ready=%b be=%b", dmem_req, req_ready, dmem_be);
    if (dmem_req !== 1'b0 || req_ready !== 1'b1 || dmem_be !== 4'b0000) begin
      miscompares++; $display("FAIL rstreq_drop got req=%b ready=%b be=%b want 0 1 0000", dmem_req, req_ready, dmem_be);
    end
    vectors++;
    @(negedge clk); rst = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h500, 32'h0F0F0F0F, 32'h0, 1);
    $display("SW  addr=%h be=%b wdata=%h resp_cyc=%0d", obs_addr, obs_be, obs_wdata, obs_resp_cyc);
    if ({obs_addr, obs_be, obs_wdata, obs_we} !== {32'h500, 4'b1111, 32'h0F0F0F0F, 1'b1} || obs_resp_cyc !== 3) begin
      miscompares++; $display("FAIL rstreq_after got %h %b %h %b cyc=%0d want 00000500 1111 0f0f0f0f 1 3", obs_addr, obs_be, obs_wdata, obs_we, obs_resp_cyc);
    end
    vectors++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_sw();
    test_loads();
    test_stores();
    test_lw_wait();
    test_misaligned();
    test_noop();
    test_rst_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
